line_mem_arbiter: RTL

- Parametrised N-port arbiter that shares one line-wide memory port (cache/physical memory side) between several pipeline requesters.
- Typical requesters are the instruction fetch port and the MEM-stage data port, plus optional extra ports.
- Each port uses the codebase's read/write/address/line-data/sel/resp handshake.
- Supports fixed-priority and round-robin grant modes.
- Latches the granted request so the memory side sees stable signals for the whole transaction.

---
 rtl/line_mem_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/line_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : line_mem_arbiter
// Brief   : N-port arbiter sharing one line-wide memory port, fixed or RR.
// Revision: 1.0 - initial release
// ============================================================================
module line_mem_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 12,
    parameter int LINE_WIDTH = 128,
    parameter int SEL_WIDTH  = 16,
    parameter int RR_MODE    = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_PORTS-1:0]             req_read,
    input  logic [NUM_PORTS-1:0]             req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_address,
    input  logic [NUM_PORTS*LINE_WIDTH-1:0]  req_wdata,
    input  logic [NUM_PORTS*SEL_WIDTH-1:0]   req_sel,
    output logic [LINE_WIDTH-1:0]            req_rdata,
    output logic [NUM_PORTS-1:0]             req_resp,
    output logic                             mem_read,
    output logic                             mem_write,
    output logic [ADDR_WIDTH-1:0]            mem_address,
    output logic [LINE_WIDTH-1:0]            mem_wdata,
    output logic [SEL_WIDTH-1:0]             mem_sel,
    input  logic [LINE_WIDTH-1:0]            mem_rdata,
    input  logic                             mem_resp,
    output logic                             busy,
    output logic [$clog2(NUM_PORTS)-1:0]     grant_id
);

    localparam int                c_ID_W = $clog2(NUM_PORTS);
    localparam logic [c_ID_W-1:0] c_LAST = c_ID_W'(NUM_PORTS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_ID_W-1:0]    r_last;
    logic [NUM_PORTS-1:0] w_active;
    logic                 w_found;
    logic [c_ID_W-1:0]    w_winner;
    logic [c_ID_W-1:0]    w_cand;

    assign w_active = req_read | req_write;

    // Fixed priority is a scan that always starts just after the top port.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = (RR_MODE != 0) ? r_last : c_LAST;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_cand = (w_cand == c_LAST) ? '0 : w_cand + 1'b1;
            if (!w_found && w_active[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_last      <= c_LAST;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            mem_sel     <= '0;
            busy        <= 1'b0;
            grant_id    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        mem_address <= req_address[int'(w_winner)*ADDR_WIDTH +: ADDR_WIDTH];
                        mem_wdata   <= req_wdata[int'(w_winner)*LINE_WIDTH +: LINE_WIDTH];
                        mem_sel     <= req_sel[int'(w_winner)*SEL_WIDTH +: SEL_WIDTH];
                        // A simultaneous read+write forwards only the write.
                        mem_write   <= req_write[w_winner];
                        mem_read    <= req_read[w_winner] & ~req_write[w_winner];
                        grant_id    <= w_winner;
                        if (RR_MODE != 0) begin
                            r_last <= w_winner;
                        end
                        busy        <= 1'b1;
                        r_state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_resp) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        busy      <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_rdata = mem_rdata;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_resp
        assign req_resp[gi] = (r_state == BUSY) && mem_resp && (grant_id == c_ID_W'(gi));
    end

endmodule
`default_nettype wire
